// File: rtl/sample_rate_bridge_pkg.sv
// Shared constants and types for the sample-rate bridge.
package sample_rate_bridge_pkg;

  localparam int OVF_W   = 8;
  localparam int OVF_MAX = 255;

  typedef enum logic {
    MODE_LATEST = 1'b0,
    MODE_QUEUE  = 1'b1
  } mode_t;

endpackage

// File: rtl/sample_rate_bridge_edge_sync.sv
// Two-flop synchronizer for the slow clock level plus rising-edge detect.
module edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic       s1;
  logic       s2;
  logic       p;
  logic [1:0] warm;

  // s2 still carries its reset value for the first two edges, so p is held
  // high until s2 reflects a real sample; a level high at release is not a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      p    <= 1'b1;
      warm <= '0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      warm <= {warm[0], 1'b1};
      p    <= warm[1] ? s2 : 1'b1;
    end
  end

  assign rise_pulse = s2 & ~p;

endmodule

// File: rtl/sample_rate_bridge.sv
// Bridges producer samples to a slow consumer clock, either latest-value
// (overwrite) or queued (FIFO) delivery, with saturating drop counter.
module sample_rate_bridge
  import sample_rate_bridge_pkg::*;
#(
  parameter int W     = 12,
  parameter int CH    = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   slow_clk,
  input  logic                   in_valid,
  input  logic [CH*W-1:0]        data_in,
  input  logic                   mode_queue,
  output logic [CH*W-1:0]        data_out,
  output logic                   out_tick,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [OVF_W-1:0]       overflow_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic             tick;
  mode_t            mode_r;
  logic [CH*W-1:0]  hold;
  logic             fresh;
  logic [CH*W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;

  logic mode_chg;
  logic is_q;
  logic full;
  logic empty;
  logic q_push;
  logic q_pop;
  logic q_drop;
  logic l_write;
  logic l_load;

  edge_sync u_edge_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_in   (slow_clk),
    .rise_pulse (tick)
  );

  // Pop decisions use the pre-push count, so a push into an empty queue is
  // never forwarded in the same cycle.
  always_comb begin
    mode_chg = (mode_t'(mode_queue) != mode_r);
    is_q     = (mode_r == MODE_QUEUE);
    full     = (count == LVL_W'(DEPTH));
    empty    = (count == '0);
    q_pop    = !mode_chg && is_q && tick && !empty;
    q_push   = !mode_chg && is_q && in_valid && (!full || q_pop);
    q_drop   = !mode_chg && is_q && in_valid && full && !q_pop;
    l_write  = !mode_chg && !is_q && in_valid;
    l_load   = !mode_chg && !is_q && tick && fresh;
  end

  always_ff @(posedge clk) begin
    if (q_push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_r       <= MODE_LATEST;
      hold         <= '0;
      fresh        <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      out_tick     <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      out_tick <= 1'b0;
      if (mode_chg) begin
        mode_r <= mode_t'(mode_queue);
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        fresh  <= 1'b0;
      end else begin
        if (q_push) wr_ptr <= wr_ptr + 1'b1;
        if (q_pop) begin
          rd_ptr   <= rd_ptr + 1'b1;
          data_out <= mem[rd_ptr];
          out_tick <= 1'b1;
        end
        count <= count + LVL_W'(q_push) - LVL_W'(q_pop);
        if (q_drop && overflow_cnt != OVF_W'(OVF_MAX))
          overflow_cnt <= overflow_cnt + 1'b1;

        if (l_write) hold <= data_in;
        if (l_load) begin
          data_out <= hold;
          out_tick <= 1'b1;
        end
        if (l_write)     fresh <= 1'b1;
        else if (l_load) fresh <= 1'b0;
      end
    end
  end

  assign fifo_level = is_q ? count : LVL_W'(fresh);

endmodule

// File: doc/sample_rate_bridge.md
SAMPLE_RATE_BRIDGE -- requirements
Module: sample_rate_bridge

Interface
REQ-001 Parameter W, default 12, bits per channel sample.
REQ-002 Parameter CH, default 2, channel count; channel k occupies bits [k*W +: W], ch0 in LSBs.
REQ-003 Parameter DEPTH, default 4, queue depth; power of two, >= 2.
REQ-004 clk  input  1  single system clock; all state on posedge clk.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 slow_clk  input  1  level of the slow consumer clock, asynchronous to clk, sampled as data.
REQ-007 in_valid  input  1  data_in holds a new sample this cycle.
REQ-008 data_in  input  CH*W  packed producer samples.
REQ-009 mode_queue  input  1  0 = LATEST (overwrite), 1 = QUEUE (FIFO).
REQ-010 data_out  output  CH*W  registered sample presented to the slow domain.
REQ-011 out_tick  output  1  one-cycle pulse in the cycle data_out takes a new value.
REQ-012 fifo_level  output  $clog2(DEPTH)+1  samples pending.
REQ-013 overflow_cnt  output  8  dropped-sample count, saturating.

Function
REQ-014 slow_clk SHALL pass through a 2-flop synchronizer (s1, s2) and a previous-value flop p; tick = s2 & ~p.
REQ-015 A slow_clk rise sampled at edge k SHALL produce tick in the cycle after edge k+1, with data_out/out_tick updating at edge k+2.
REQ-016 LATEST mode: each in_valid SHALL overwrite a holding register and set a fresh flag; fifo_level = fresh (0 or 1).
REQ-017 LATEST mode: on tick with fresh=1, data_out SHALL load the holding register, out_tick SHALL pulse, fresh SHALL clear unless in_valid is high that cycle (new sample stays fresh).
REQ-018 QUEUE mode: in_valid SHALL push data_in; tick SHALL pop the head into data_out with out_tick pulsing.
REQ-019 Tick with nothing pending (fresh=0 or queue empty) SHALL hold data_out; out_tick stays 0.
REQ-020 No fall-through: a push into an empty queue in the same cycle as tick SHALL NOT be popped that cycle.
REQ-021 Push and pop in the same cycle at full SHALL both occur; level unchanged; no overflow.
REQ-022 Push at full without pop SHALL drop the sample, leave queue contents unchanged, and increment overflow_cnt.
REQ-023 overflow_cnt SHALL saturate at 255; LATEST-mode overwrites are not overflows.
REQ-024 A change of mode_queue (vs. its registered copy) SHALL flush queue and fresh flag (level 0 next cycle), ignore that cycle's in_valid and tick, and keep data_out and overflow_cnt.
REQ-025 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; level range 0..DEPTH.

Reset
REQ-026 reset_n low SHALL asynchronously clear data_out, out_tick, fifo_level, overflow_cnt, pointers, fresh, s1, s2, registered mode (to 0).
REQ-027 p SHALL reset to 1, so slow_clk high at reset release yields no tick until a low-to-high transition is observed.
REQ-028 Reset asserted mid-operation SHALL discard all pending samples; no out_tick in the cycle after release.

Structure
REQ-029 Package sample_rate_bridge_pkg SHALL hold OVF_W = 8, OVF_MAX = 255 and the mode enum {MODE_LATEST, MODE_QUEUE}.
REQ-030 Synchronizer plus edge detect SHALL be sub-module edge_sync (ports clk, reset_n, async_in, rise_pulse); queue storage is inline.

Verification
REQ-031 LATEST, W=12 CH=2: push 0x001_002, 0x003_004, then one slow_clk rise -> data_out = 0x003_004, one out_tick, fifo_level 0.
REQ-032 QUEUE DEPTH=4: push 6 samples A..F without tick -> level 4, overflow_cnt 2; four ticks -> data_out A, B, C, D, one out_tick each.
REQ-033 QUEUE, queue full, push G coincident with tick -> pops A, G enqueued, level 4, overflow_cnt unchanged.
REQ-034 reset_n released with slow_clk held high for 10 cycles -> no out_tick; then slow_clk low-then-high with one pending sample -> exactly one out_tick.
REQ-035 Force 300 drops -> overflow_cnt = 255; toggle mode_queue with 3 pending -> level 0 next cycle, data_out and overflow_cnt unchanged.
REQ-036 Empty queue, push coincident with tick -> no out_tick that cycle; next tick pops the sample.
